// File: rtl/sample_pwm_out.sv
// sample_pwm_out: audio output stage fed by the mixer.
// A small FIFO buffers mixed samples; each sample_now strobe pops one sample
// into the duty register, and a free-running PWM counter renders it as a
// pulse-width-modulated output whose period matches the sample period.
// An underrun pulse flags a strobe that found the FIFO empty.
// Build option: define UNDERRUN_MUTE_EN to load midscale (silence) into the
// duty register on underrun; otherwise the last played sample is held.
module sample_pwm_out #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_sample_now,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic                     o_pwm_out,
    output logic                     o_underrun,
    output logic [$clog2(DEPTH):0]   o_fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] MIDSCALE   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Playback state
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_pwm_cnt;
    logic             r_pwm_out;
    logic             r_underrun;

    // Combinational control
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_underrun;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_duty_nxt;
    logic [WIDTH-1:0] w_pwm_cnt_nxt;

    assign w_in_ready = (r_count < FULL_COUNT);
    assign w_push     = i_in_valid && w_in_ready;
    // A strobe on an empty FIFO never pops, even if a push lands in the same
    // cycle: the pushed sample waits for the next strobe.
    assign w_pop      = i_sample_now && (r_count != {CNT_W{1'b0}});
    assign w_underrun = i_sample_now && (r_count == {CNT_W{1'b0}});

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Duty selection: new sample on pop, underrun policy on an empty strobe.
    always_comb begin
        w_duty_nxt = r_duty;
        if (w_pop) begin
            w_duty_nxt = r_mem[r_rd_ptr];
        end else if (w_underrun) begin
`ifdef UNDERRUN_MUTE_EN
            w_duty_nxt = MIDSCALE;
`else
            w_duty_nxt = r_duty;
`endif
        end else begin
            w_duty_nxt = r_duty;
        end
    end

    // PWM counter restarts after every strobe so each sample starts a fresh period.
    always_comb begin
        w_pwm_cnt_nxt = r_pwm_cnt + WIDTH'(1);
        if (i_sample_now) begin
            w_pwm_cnt_nxt = {WIDTH{1'b0}};
        end else begin
            w_pwm_cnt_nxt = r_pwm_cnt + WIDTH'(1);
        end
    end

    // FIFO storage write; contents are cleared on reset so stale audio never replays.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Playback registers: duty, PWM counter, PWM output and underrun pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_duty     <= MIDSCALE;
            r_pwm_cnt  <= {WIDTH{1'b0}};
            r_pwm_out  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_duty     <= w_duty_nxt;
            r_pwm_cnt  <= w_pwm_cnt_nxt;
            r_pwm_out  <= (r_pwm_cnt < r_duty);
            r_underrun <= w_underrun;
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_pwm_out    = r_pwm_out;
    assign o_underrun   = r_underrun;
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_sample_pwm_out.sv
// Testbench for sample_pwm_out: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model of the stage.
module tb_sample_pwm_out;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 1 << WIDTH;
    localparam int MID    = 1 << (WIDTH - 1);

    logic                   clk;
    logic                   n_rst;
    logic                   sample_now;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   pwm_out;
    logic                   underrun;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    sample_pwm_out #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_sample_now (sample_now),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_pwm_out    (pwm_out),
        .o_underrun   (underrun),
        .o_fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // FIFO as a queue; the PWM is "high while the phase since the last
    // period start is below the duty", seen one cycle late at the output.
    int mq[$];
    int m_duty;
    int m_phase;
    bit m_pwm;
    bit m_und;

    task automatic model_reset();
        mq.delete();
        m_duty  = MID;
        m_phase = 0;
        m_pwm   = 1'b0;
        m_und   = 1'b0;
    endtask

    task automatic model_step();
        bit do_push;
        do_push = in_valid && (mq.size() < DEPTH);
        m_pwm   = (m_phase < m_duty);
        m_und   = sample_now && (mq.size() == 0);
        if (sample_now) begin
            if (mq.size() > 0) begin
                m_duty = mq.pop_front();
            end else begin
`ifdef UNDERRUN_MUTE_EN
                m_duty = MID;
`endif
            end
            m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % PERIOD;
        end
        if (do_push) mq.push_back(int'(in_data));
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) model_reset();
        else        model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("m_in_ready",   32'(in_ready),   32'(mq.size() < DEPTH));
            chk("m_pwm_out",    32'(pwm_out),    32'(m_pwm));
            chk("m_underrun",   32'(underrun),   32'(m_und));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [WIDTH-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count pwm_out high cycles over one full period (no strobes inside).
    task automatic measure(input string name, input int exp_h);
        int h;
        h = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            h += int'(pwm_out);
        end
        chk(name, 32'(h), 32'(exp_h));
    endtask

    task automatic strobe_meas(input string name, input bit exp_und, input int exp_h);
        sample_now = 1'b1;
        @(negedge clk);
        sample_now = 1'b0;
        chk({name, "_und"}, 32'(underrun), 32'(exp_und));
        measure({name, "_high"}, exp_h);
    endtask

    initial begin
        n_rst      = 1'b0;
        sample_now = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_pwm",   32'(pwm_out),    32'd0);
        chk("rst_und",   32'(underrun),   32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(in_ready),   32'd1);
        n_rst  = 1'b1;
        chk_en = 1'b1;

        // Idle: first strobe underruns, output sits at 50 percent
        strobe_meas("idle", 1'b1, 128);
        chk("idle_count", 32'(fifo_count), 32'd0);

        // Single sample 0x40 -> 64 high of 256
        push(8'h40);
        chk("p40_count", 32'(fifo_count), 32'd1);
        strobe_meas("p40", 1'b0, 64);
        chk("p40_count0", 32'(fifo_count), 32'd0);

        // Fill, back-pressure, then pop frees a slot for the held 5th sample
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(in_ready),   32'd0);
        in_valid = 1'b1;
        in_data  = 8'h50;
        repeat (3) @(negedge clk);
        chk("held_count", 32'(fifo_count), 32'd4);
        chk("held_ready", 32'(in_ready),   32'd0);
        sample_now = 1'b1;
        @(negedge clk);
        sample_now = 1'b0;
        chk("pop_count", 32'(fifo_count), 32'd3);
        chk("pop_ready", 32'(in_ready),   32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("refill_count", 32'(fifo_count), 32'd4);
        measure("ord10", 8'h10);
        strobe_meas("ord20", 1'b0, 8'h20);
        strobe_meas("ord30", 1'b0, 8'h30);
        strobe_meas("ord40", 1'b0, 8'h40);
        strobe_meas("ord50", 1'b0, 8'h50);
        chk("ord_count0", 32'(fifo_count), 32'd0);

        // Underrun with simultaneous push: no bypass
        push(8'hC0);
        strobe_meas("pC0", 1'b0, 8'hC0);
        in_valid   = 1'b1;
        in_data    = 8'h20;
        sample_now = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        sample_now = 1'b0;
        chk("ur_pulse", 32'(underrun),   32'd1);
        chk("ur_count", 32'(fifo_count), 32'd1);
`ifdef UNDERRUN_MUTE_EN
        measure("ur_duty", 8'h80);
`else
        measure("ur_duty", 8'hC0);
`endif
        strobe_meas("ur_next", 1'b0, 8'h20);

        // Reset mid-period with three samples queued
        push(8'h60); push(8'h70); push(8'h80); push(8'h90);
        sample_now = 1'b1;
        @(negedge clk);
        sample_now = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_pwm_hi", 32'(pwm_out),    32'd1);
        chk("mid_count",  32'(fifo_count), 32'd3);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_pwm",   32'(pwm_out),    32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_und",   32'(underrun),   32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        strobe_meas("post_rst", 1'b1, 128);

        // Randomized traffic against the model, including close strobes
        for (int c = 0; c < 4000; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = WIDTH'($urandom);
            sample_now = ($urandom_range(0, 99) < 3);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        sample_now = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_pwm_out.md
# sample_pwm_out

Audio output stage directly downstream of the sample-rate divider. Buffers mixed samples from the mixer in a small FIFO. Pops one sample per `sample_now` strobe and renders it as a PWM waveform whose period matches the 256-cycle sample period. Reports underruns when the mixer fails to keep up.

## Interface
- `WIDTH`, 8: sample width and PWM counter width; PWM period is 2^WIDTH cycles.
- `DEPTH`, 4: FIFO depth in samples; power of two, ≥2.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `sample_now`  in  1  one-cycle strobe from the sample-rate divider.
- `in_data`  in  WIDTH  unsigned sample from the mixer; midscale 2^(WIDTH-1) = silence.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept; combinational: `fifo_count < DEPTH`.
- `pwm_out`  out  1  registered PWM audio output.
- `underrun`  out  1  one-cycle registered pulse: `sample_now` arrived with FIFO empty.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: `in_valid && in_ready` writes `in_data` at the write pointer. Count increments, except on a simultaneous pop.
- Pop: on `sample_now` with count > 0, the head entry loads into `duty` and the read pointer advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous push and pop: both occur and the count is unchanged.
- When full, `in_ready` is 0. A pop in that cycle frees a slot, so `in_ready` is 1 the next cycle.
- Empty with push and `sample_now` in the same cycle: pop sees empty, so `underrun` asserts and the pushed sample stays in the FIFO. There is no bypass.
- Underrun: `duty` behaviour is set by configuration (see below). The FIFO is untouched.
- PWM counter `pwm_cnt` (WIDTH bits):
  - Increments every cycle and wraps 2^WIDTH−1 → 0.
  - Is forced to 0 on the cycle after any `sample_now`, underrun included.
- `pwm_out` is registered as `pwm_cnt < duty`:
  - duty 0 → constant 0.
  - duty 2^WIDTH−1 → high 255 of every 256 cycles (WIDTH=8).
- `sample_now` pulses closer than 2^WIDTH cycles apart truncate the PWM period. This is legal and the only effect.
- Reset values: `pwm_out`=0, `underrun`=0, `fifo_count`=0, pointers 0, `pwm_cnt`=0, `duty`=2^(WIDTH-1). Asserting `n_rst` mid-operation discards all FIFO contents immediately.

## Timing
- Push in cycle N → `fifo_count` updated in N+1.
- `sample_now` in cycle N → `duty` and `pwm_cnt`=0 take effect in N+1. `pwm_out` reflects the new duty from N+2, one register stage.
- `underrun` is high in cycle N+1 only.
- `in_ready` has no register delay relative to `fifo_count`.
- Minimum latency from push into an empty FIFO to that sample on `pwm_out`: the next `sample_now` plus 2 cycles.

## Configuration
- `UNDERRUN_MUTE_EN` defined: on underrun, `duty` loads midscale 2^(WIDTH-1), so output goes silent.
- `UNDERRUN_MUTE_EN` undefined: on underrun, `duty` holds the last played sample.
- `underrun` pulses in both builds.

## Test plan
- Reset, then idle: `pwm_out` high exactly 128 of every 256 cycles after the first `sample_now`. `in_ready`=1 and `fifo_count`=0.
- Push 0x40, then `sample_now`: from 2 cycles after the strobe, `pwm_out` is high for 64 cycles, then low for 192, repeating. `fifo_count` returns to 0.
- Push 5 samples with DEPTH=4, no strobes: `in_ready` drops after the 4th push and the 5th is held off. After one `sample_now`, the 5th is accepted and `fifo_count`=4.
- Full FIFO with `in_valid` held and `sample_now`: pop and push occur on consecutive cycles and the order is preserved. Popped values 0x10, 0x20, 0x30, 0x40, 0x50 match push order.
- Empty FIFO after playing 0xC0, then `sample_now` with a push of 0x20 in the same cycle:
  - `underrun` pulses one cycle.
  - duty becomes 0x80 (MUTE_EN) or stays 0xC0 (not defined).
  - `fifo_count`=1 and the next strobe plays 0x20.
- Assert `n_rst` mid-PWM-period with 3 samples queued: `pwm_out`=0, `fifo_count`=0 and `underrun`=0 immediately. After release, the first strobe underruns.
